// File: rtl/alu_issue_if.sv
// Bundle between the execute-stage scheduler and its environment: dispatch
// request, CDB broadcast, ALU back-pressure, the registered issue packet and
// the occupancy count.
//
// Handshake semantics: a dispatch transfer happens on a rising clock edge
// where disp_valid && disp_ready. disp_ready depends only on the registered
// occupancy, never on disp_valid. The issue packet has no ready signal.
// alu_stall is sampled in the cycle before the issue register loads, and
// issue_valid marks a packet that is present for exactly one cycle.
interface alu_issue_if #(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              disp_valid;
    logic              disp_ready;
    logic              disp_src1_rdy;
    logic              disp_src2_rdy;
    logic [TAG_W-1:0]  disp_src1_tag;
    logic [TAG_W-1:0]  disp_src2_tag;
    logic [DATA_W-1:0] disp_src1_val;
    logic [DATA_W-1:0] disp_src2_val;
    logic              disp_dst_valid;
    logic [TAG_W-1:0]  disp_dst_tag;
    logic [2:0]        disp_alu_ctrl;
    logic              disp_funct7;
    logic              disp_pred;
    logic [DATA_W-1:0] disp_target;

    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;

    logic              alu_stall;

    logic              issue_valid;
    logic [DATA_W-1:0] issue_src_1;
    logic [DATA_W-1:0] issue_src_2;
    logic              issue_dst_valid;
    logic [TAG_W-1:0]  issue_dst_tag;
    logic [2:0]        issue_alu_ctrl;
    logic              issue_funct7;
    logic              issue_pred;
    logic [DATA_W-1:0] issue_target;

    logic [CNT_W-1:0]  count;

    // Environment side: dispatch stage, CDB and ALU.
    modport master (
        output disp_valid, disp_src1_rdy, disp_src2_rdy, disp_src1_tag, disp_src2_tag,
               disp_src1_val, disp_src2_val, disp_dst_valid, disp_dst_tag,
               disp_alu_ctrl, disp_funct7, disp_pred, disp_target,
               cdb_valid, cdb_tag, cdb_data, alu_stall,
        input  disp_ready, issue_valid, issue_src_1, issue_src_2, issue_dst_valid,
               issue_dst_tag, issue_alu_ctrl, issue_funct7, issue_pred, issue_target,
               count
    );

    // Issue queue side.
    modport slave (
        input  disp_valid, disp_src1_rdy, disp_src2_rdy, disp_src1_tag, disp_src2_tag,
               disp_src1_val, disp_src2_val, disp_dst_valid, disp_dst_tag,
               disp_alu_ctrl, disp_funct7, disp_pred, disp_target,
               cdb_valid, cdb_tag, cdb_data, alu_stall,
        output disp_ready, issue_valid, issue_src_1, issue_src_2, issue_dst_valid,
               issue_dst_tag, issue_alu_ctrl, issue_funct7, issue_pred, issue_target,
               count
    );
endinterface

// File: rtl/alu_issue_queue.sv
// Reservation station and oldest-first scheduler for the single-cycle ALU.
// Entries are kept compacted with slot 0 the oldest, so the select is a
// simple lowest-index priority pick.
//
// Optional feature macro: ALU_ISSUE_WAKEUP_BYPASS_EN. When defined, sources
// matched by the current CDB broadcast count as ready for this cycle's select
// and the broadcast value is forwarded into the issue packet.
module alu_issue_queue #(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32
) (
    input logic        clk,
    input logic        rst_n,
    input logic        flush,
    alu_issue_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    typedef struct packed {
        logic              valid;
        logic              s1_rdy;
        logic [TAG_W-1:0]  s1_tag;
        logic [DATA_W-1:0] s1_val;
        logic              s2_rdy;
        logic [TAG_W-1:0]  s2_tag;
        logic [DATA_W-1:0] s2_val;
        logic              dst_valid;
        logic [TAG_W-1:0]  dst_tag;
        logic [2:0]        alu_ctrl;
        logic              funct7;
        logic              pred;
        logic [DATA_W-1:0] target;
    } entry_t;

    entry_t            q      [DEPTH];
    entry_t            woke   [DEPTH];
    entry_t            q_next [DEPTH];
    entry_t            disp_e;
    entry_t            sel_e;
    logic [DEPTH-1:0]  wake1;
    logic [DEPTH-1:0]  wake2;
    logic [DEPTH-1:0]  cand;
    logic              sel_found;
    logic [IDX_W-1:0]  sel_idx;
    logic              disp_fire;
    logic              do_issue;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic [CNT_W-1:0]  wr_idx;

    logic              iss_valid;
    logic [DATA_W-1:0] iss_src_1;
    logic [DATA_W-1:0] iss_src_2;
    logic              iss_dst_valid;
    logic [TAG_W-1:0]  iss_dst_tag;
    logic [2:0]        iss_alu_ctrl;
    logic              iss_funct7;
    logic              iss_pred;
    logic [DATA_W-1:0] iss_target;

    // A same-cycle issue is deliberately not credited, keeping this path short.
    assign bus.disp_ready = (cnt != CNT_W'(DEPTH));
    assign bus.count      = cnt;
    assign disp_fire      = bus.disp_valid && bus.disp_ready;

    // CDB tag match per stored source; woke[] is the queue with this cycle's wakeups applied.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            wake1[i] = q[i].valid && !q[i].s1_rdy && bus.cdb_valid && (q[i].s1_tag == bus.cdb_tag);
            wake2[i] = q[i].valid && !q[i].s2_rdy && bus.cdb_valid && (q[i].s2_tag == bus.cdb_tag);
            woke[i]  = q[i];
            if (wake1[i]) begin
                woke[i].s1_rdy = 1'b1;
                woke[i].s1_val = bus.cdb_data;
            end
            if (wake2[i]) begin
                woke[i].s2_rdy = 1'b1;
                woke[i].s2_val = bus.cdb_data;
            end
        end
    end

`ifdef ALU_ISSUE_WAKEUP_BYPASS_EN
    // Candidates include sources being woken right now (back-to-back dependent issue).
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            cand[i] = woke[i].valid && woke[i].s1_rdy && woke[i].s2_rdy;
        end
    end
`else
    // Candidates use registered ready bits only; a woken entry waits one cycle.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            cand[i] = q[i].valid && q[i].s1_rdy && q[i].s2_rdy;
        end
    end
`endif

    // Oldest-first select: lowest-index candidate wins.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (cand[i]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    // woke[] equals q[] for already-ready entries, so this also carries bypassed data.
    assign sel_e    = woke[sel_idx];
    assign do_issue = sel_found && !bus.alu_stall;

    // Build the dispatched entry, catching a broadcast of its own producer tag.
    always_comb begin
        disp_e           = '0;
        disp_e.valid     = 1'b1;
        disp_e.s1_tag    = bus.disp_src1_tag;
        disp_e.s2_tag    = bus.disp_src2_tag;
        disp_e.s1_rdy    = bus.disp_src1_rdy ||
                           (bus.cdb_valid && (bus.disp_src1_tag == bus.cdb_tag));
        disp_e.s2_rdy    = bus.disp_src2_rdy ||
                           (bus.cdb_valid && (bus.disp_src2_tag == bus.cdb_tag));
        disp_e.s1_val    = bus.disp_src1_rdy ? bus.disp_src1_val : bus.cdb_data;
        disp_e.s2_val    = bus.disp_src2_rdy ? bus.disp_src2_val : bus.cdb_data;
        disp_e.dst_valid = bus.disp_dst_valid;
        disp_e.dst_tag   = bus.disp_dst_tag;
        disp_e.alu_ctrl  = bus.disp_alu_ctrl;
        disp_e.funct7    = bus.disp_funct7;
        disp_e.pred      = bus.disp_pred;
        disp_e.target    = bus.disp_target;
    end

    // Next queue image: apply wakeups, compact over the issued slot, then append the dispatch.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            q_next[i] = woke[i];
        end
        if (do_issue) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                if (IDX_W'(i) >= sel_idx) begin
                    q_next[i] = woke[i + 1];
                end
            end
            q_next[DEPTH-1] = '0;
        end
        wr_idx = cnt - CNT_W'(do_issue);
        if (disp_fire) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CNT_W'(i) == wr_idx) begin
                    q_next[i] = disp_e;
                end
            end
        end
        cnt_next = cnt + CNT_W'(disp_fire) - CNT_W'(do_issue);
    end

    // Queue storage and occupancy; flush discards everything including same-cycle traffic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q[i] <= '0;
            end
        end else if (flush) begin
            cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q[i] <= '0;
            end
        end else begin
            cnt <= cnt_next;
            for (int i = 0; i < DEPTH; i++) begin
                q[i] <= q_next[i];
            end
        end
    end

    // Issue register: loads the selected entry; valid for one cycle per issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_valid     <= 1'b0;
            iss_src_1     <= '0;
            iss_src_2     <= '0;
            iss_dst_valid <= 1'b0;
            iss_dst_tag   <= '0;
            iss_alu_ctrl  <= '0;
            iss_funct7    <= 1'b0;
            iss_pred      <= 1'b0;
            iss_target    <= '0;
        end else if (flush) begin
            iss_valid     <= 1'b0;
            iss_src_1     <= '0;
            iss_src_2     <= '0;
            iss_dst_valid <= 1'b0;
            iss_dst_tag   <= '0;
            iss_alu_ctrl  <= '0;
            iss_funct7    <= 1'b0;
            iss_pred      <= 1'b0;
            iss_target    <= '0;
        end else begin
            iss_valid <= do_issue;
            if (do_issue) begin
                iss_src_1     <= sel_e.s1_val;
                iss_src_2     <= sel_e.s2_val;
                iss_dst_valid <= sel_e.dst_valid;
                iss_dst_tag   <= sel_e.dst_tag;
                iss_alu_ctrl  <= sel_e.alu_ctrl;
                iss_funct7    <= sel_e.funct7;
                iss_pred      <= sel_e.pred;
                iss_target    <= sel_e.target;
            end
        end
    end

    assign bus.issue_valid     = iss_valid;
    assign bus.issue_src_1     = iss_src_1;
    assign bus.issue_src_2     = iss_src_2;
    assign bus.issue_dst_valid = iss_dst_valid;
    assign bus.issue_dst_tag   = iss_dst_tag;
    assign bus.issue_alu_ctrl  = iss_alu_ctrl;
    assign bus.issue_funct7    = iss_funct7;
    assign bus.issue_pred      = iss_pred;
    assign bus.issue_target    = iss_target;
endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue (DEPTH=4, TAG_W=4, DATA_W=32).
// Expectations are hand-derived; the wakeup scenarios follow the
// ALU_ISSUE_WAKEUP_BYPASS_EN setting of the build.
module tb_alu_issue_queue;
    logic clk;
    logic rst_n;
    logic flush;
    int   n_checks;
    int   n_errors;

    alu_issue_if #(.DEPTH(4), .TAG_W(4), .DATA_W(32)) bus ();

    alu_issue_queue #(.DEPTH(4), .TAG_W(4), .DATA_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_disp();
        bus.disp_valid     = 1'b0;
        bus.disp_src1_rdy  = 1'b0;
        bus.disp_src2_rdy  = 1'b0;
        bus.disp_src1_tag  = '0;
        bus.disp_src2_tag  = '0;
        bus.disp_src1_val  = '0;
        bus.disp_src2_val  = '0;
        bus.disp_dst_valid = 1'b0;
        bus.disp_dst_tag   = '0;
        bus.disp_alu_ctrl  = '0;
        bus.disp_funct7    = 1'b0;
        bus.disp_pred      = 1'b0;
        bus.disp_target    = '0;
    endtask

    task automatic clear_cdb();
        bus.cdb_valid = 1'b0;
        bus.cdb_tag   = '0;
        bus.cdb_data  = '0;
    endtask

    task automatic set_disp(input logic r1, input logic [3:0] t1, input logic [31:0] v1,
                            input logic r2, input logic [3:0] t2, input logic [31:0] v2,
                            input logic [3:0] dst);
        bus.disp_valid     = 1'b1;
        bus.disp_src1_rdy  = r1;
        bus.disp_src1_tag  = t1;
        bus.disp_src1_val  = v1;
        bus.disp_src2_rdy  = r2;
        bus.disp_src2_tag  = t2;
        bus.disp_src2_val  = v2;
        bus.disp_dst_valid = 1'b1;
        bus.disp_dst_tag   = dst;
        bus.disp_alu_ctrl  = 3'd0;
        bus.disp_funct7    = 1'b0;
        bus.disp_pred      = 1'b0;
        bus.disp_target    = '0;
    endtask

    task automatic set_cdb(input logic [3:0] tag, input logic [31:0] data);
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = tag;
        bus.cdb_data  = data;
    endtask

    task automatic expect_issue(input string tag, input logic [3:0] dst,
                                input logic [31:0] s1, input logic [31:0] s2, input int cnt);
        check_eq({tag, "_valid"}, 64'(bus.issue_valid), 64'd1);
        check_eq({tag, "_dst"},   64'(bus.issue_dst_tag), 64'(dst));
        check_eq({tag, "_src1"},  64'(bus.issue_src_1), 64'(s1));
        check_eq({tag, "_src2"},  64'(bus.issue_src_2), 64'(s2));
        check_eq({tag, "_count"}, 64'(bus.count), 64'(cnt));
    endtask

    task automatic expect_idle(input string tag, input int cnt);
        check_eq({tag, "_valid"}, 64'(bus.issue_valid), 64'd0);
        check_eq({tag, "_count"}, 64'(bus.count), 64'(cnt));
    endtask

    // Broadcast a tag and check the woken entry issues with the right latency.
    task automatic wake_issue(input string tag, input logic [3:0] ctag, input logic [31:0] cdata,
                              input logic [3:0] dst, input logic [31:0] s1, input logic [31:0] s2,
                              input int cnt);
        set_cdb(ctag, cdata);
        step();
        clear_cdb();
`ifdef ALU_ISSUE_WAKEUP_BYPASS_EN
        expect_issue(tag, dst, s1, s2, cnt);
`else
        check_eq({tag, "_wait"}, 64'(bus.issue_valid), 64'd0);
        step();
        expect_issue(tag, dst, s1, s2, cnt);
`endif
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rst_n       = 1'b1;
        flush       = 1'b0;
        bus.alu_stall = 1'b0;
        clear_disp();
        clear_cdb();
        #2 rst_n = 1'b0;
        step();
        step();
        check_eq("rst_count", 64'(bus.count), 64'd0);
        check_eq("rst_issue_valid", 64'(bus.issue_valid), 64'd0);
        check_eq("rst_disp_ready", 64'(bus.disp_ready), 64'd1);
        check_eq("rst_src1", 64'(bus.issue_src_1), 64'd0);
        check_eq("rst_target", 64'(bus.issue_target), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Single ready op: written at edge N, issued at edge N+1; side fields pass through.
        set_disp(1'b1, 4'd0, 32'd5, 1'b1, 4'd0, 32'd7, 4'd3);
        bus.disp_alu_ctrl = 3'b101;
        bus.disp_funct7   = 1'b1;
        bus.disp_pred     = 1'b1;
        bus.disp_target   = 32'hDEAD_BEEF;
        step();
        clear_disp();
        expect_idle("single_wr", 1);
        step();
        expect_issue("single", 4'd3, 32'd5, 32'd7, 0);
        check_eq("single_dstv", 64'(bus.issue_dst_valid), 64'd1);
        check_eq("single_ctrl", 64'(bus.issue_alu_ctrl), 64'd5);
        check_eq("single_f7", 64'(bus.issue_funct7), 64'd1);
        check_eq("single_pred", 64'(bus.issue_pred), 64'd1);
        check_eq("single_target", 64'(bus.issue_target), 64'hDEAD_BEEF);
        step();
        expect_idle("single_after", 0);

        // Older op waiting on tag 9, younger ready op overtakes it.
        set_disp(1'b0, 4'd9, 32'd0, 1'b1, 4'd0, 32'd2, 4'd4);
        step();
        set_disp(1'b1, 4'd0, 32'd10, 1'b1, 4'd0, 32'd20, 4'd5);
        step();
        clear_disp();
        expect_idle("ooo_wr", 2);
        step();
        expect_issue("ooo_young", 4'd5, 32'd10, 32'd20, 1);
        wake_issue("ooo_old", 4'd9, 32'h100, 4'd4, 32'h100, 32'd2, 0);
        step();
        expect_idle("ooo_after", 0);

        // Fill with waiting ops (tags 1..4, dst 10..13), then refuse a dispatch when full.
        for (int i = 0; i < 4; i++) begin
            set_disp(1'b0, 4'(i + 1), 32'd0, 1'b1, 4'd0, 32'hA0 + 32'(i), 4'(10 + i));
            step();
        end
        clear_disp();
        expect_idle("full", 4);
        check_eq("full_ready", 64'(bus.disp_ready), 64'd0);
        set_disp(1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 32'd1, 4'd7);
        step();
        clear_disp();
        expect_idle("full_refuse", 4);
        wake_issue("wake_slot2", 4'd3, 32'h33, 4'd12, 32'h33, 32'hA2, 3);
        check_eq("slot2_ready", 64'(bus.disp_ready), 64'd1);
        wake_issue("wake_shift", 4'd4, 32'h44, 4'd13, 32'h44, 32'hA3, 2);
        wake_issue("wake_slot0", 4'd1, 32'h11, 4'd10, 32'h11, 32'hA0, 1);
        wake_issue("wake_last", 4'd2, 32'h22, 4'd11, 32'h22, 32'hA1, 0);
        step();
        expect_idle("fill_after", 0);

        // Both sources of one entry woken by the same broadcast.
        set_disp(1'b0, 4'd5, 32'd0, 1'b0, 4'd5, 32'd0, 4'd6);
        step();
        clear_disp();
        wake_issue("both_src", 4'd5, 32'h55, 4'd6, 32'h55, 32'h55, 0);
        step();

        // Dispatch landing in slot count-1 while the older entry issues.
        set_disp(1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 32'd1, 4'd1);
        step();
        set_disp(1'b1, 4'd0, 32'd2, 1'b1, 4'd0, 32'd2, 4'd2);
        step();
        clear_disp();
        expect_issue("disp_iss_x", 4'd1, 32'd1, 32'd1, 1);
        step();
        expect_issue("disp_iss_y", 4'd2, 32'd2, 32'd2, 0);
        step();

        // Stall holds two ready ops; then fill to full and release with dispatch still offered.
        bus.alu_stall = 1'b1;
        set_disp(1'b1, 4'd0, 32'h11, 1'b1, 4'd0, 32'h12, 4'd1);
        step();
        set_disp(1'b1, 4'd0, 32'h21, 1'b1, 4'd0, 32'h22, 4'd2);
        step();
        clear_disp();
        for (int i = 0; i < 3; i++) begin
            step();
            expect_idle("stall", 2);
        end
        set_disp(1'b1, 4'd0, 32'h31, 1'b1, 4'd0, 32'h32, 4'd3);
        step();
        set_disp(1'b1, 4'd0, 32'h41, 1'b1, 4'd0, 32'h42, 4'd4);
        step();
        expect_idle("stall_full", 4);
        set_disp(1'b1, 4'd0, 32'h99, 1'b1, 4'd0, 32'h99, 4'd9);
        bus.alu_stall = 1'b0;
        step();
        clear_disp();
        expect_issue("rel_1", 4'd1, 32'h11, 32'h12, 3);
        step();
        expect_issue("rel_2", 4'd2, 32'h21, 32'h22, 2);
        step();
        expect_issue("rel_3", 4'd3, 32'h31, 32'h32, 1);
        step();
        expect_issue("rel_4", 4'd4, 32'h41, 32'h42, 0);
        step();
        expect_idle("rel_after", 0);

        // Dispatch-cycle wakeup of src2 by tag 6.
        set_disp(1'b1, 4'd0, 32'h11, 1'b0, 4'd6, 32'd0, 4'd8);
        set_cdb(4'd6, 32'hABCD);
        step();
        clear_disp();
        clear_cdb();
        expect_idle("dwake_wr", 1);
        step();
        expect_issue("dwake", 4'd8, 32'h11, 32'hABCD, 0);
        step();

        // Flush with three entries and an issue about to happen; same-cycle traffic ignored.
        bus.alu_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_disp(1'b1, 4'd0, 32'(i), 1'b1, 4'd0, 32'(i), 4'(i + 1));
            step();
        end
        clear_disp();
        expect_idle("pre_flush", 3);
        bus.alu_stall = 1'b0;
        flush = 1'b1;
        set_disp(1'b1, 4'd0, 32'd7, 1'b1, 4'd0, 32'd7, 4'd7);
        set_cdb(4'd2, 32'h77);
        step();
        flush = 1'b0;
        clear_disp();
        clear_cdb();
        expect_idle("flush", 0);
        check_eq("flush_ready", 64'(bus.disp_ready), 64'd1);
        step();
        expect_idle("flush_after", 0);

        // Asynchronous reset while an issue packet is being presented.
        bus.alu_stall = 1'b1;
        set_disp(1'b1, 4'd0, 32'h4, 1'b1, 4'd0, 32'h4, 4'd4);
        step();
        set_disp(1'b1, 4'd0, 32'h5, 1'b1, 4'd0, 32'h5, 4'd5);
        step();
        clear_disp();
        bus.alu_stall = 1'b0;
        step();
        expect_issue("pre_rst", 4'd4, 32'h4, 32'h4, 1);
        #2 rst_n = 1'b0;
        #1;
        expect_idle("async_rst", 0);
        check_eq("async_rst_src1", 64'(bus.issue_src_1), 64'd0);
        check_eq("async_rst_dst", 64'(bus.issue_dst_tag), 64'd0);
        check_eq("async_rst_ready", 64'(bus.disp_ready), 64'd1);
        step();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        expect_idle("post_rst", 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/alu_issue_queue.md
Name: alu_issue_queue

Overview:
- Reservation station and scheduler for the single-cycle integer ALU in the execute stage.
- Accepts dispatched ALU ops with source operands that may still be pending. Captures results broadcast on the common data bus (CDB) to wake those operands.
- Each cycle, selects the oldest fully-ready entry and drives one registered issue packet to the ALU: src_1, src_2, dst tag, alu_ctrl, funct7, pred, target.

Parameters:
- DEPTH, 4, number of entries (power of two, 2..16).
- TAG_W, 4, physical/ROB tag width.
- DATA_W, 32, operand width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous squash of all entries and of the issue register.
- disp_valid  in  1  dispatch request.
- disp_ready  out  1  queue can accept; equals (count != DEPTH).
- disp_src1_rdy / disp_src2_rdy  in  1 each  operand value already valid.
- disp_src1_tag / disp_src2_tag  in  TAG_W each  producer tag when not ready.
- disp_src1_val / disp_src2_val  in  DATA_W each  operand value when ready.
- disp_dst_valid  in  1  op writes a destination.
- disp_dst_tag  in  TAG_W  destination tag.
- disp_alu_ctrl  in  3  funct3-style ALU op.
- disp_funct7  in  1  sub/arith-shift select.
- disp_pred  in  1  branch prediction bit.
- disp_target  in  DATA_W  predicted target.
- cdb_valid  in  1  result broadcast valid.
- cdb_tag  in  TAG_W  broadcast tag.
- cdb_data  in  DATA_W  broadcast value.
- alu_stall  in  1  ALU cannot accept this cycle.
- issue_valid  out  1  registered issue packet valid.
- issue_src_1 / issue_src_2  out  DATA_W each  operands.
- issue_dst_valid  out  1  destination valid.
- issue_dst_tag  out  TAG_W  destination tag.
- issue_alu_ctrl  out  3  ALU op.
- issue_funct7  out  1  sub/arith-shift select.
- issue_pred  out  1  prediction bit.
- issue_target  out  DATA_W  predicted target.
- count  out  $clog2(DEPTH)+1  occupied entries.

Behaviour:
- Reset (rst_n low, async): all entry valid bits 0, count 0, issue_valid 0, every issue_* field 0. disp_ready is 1 once count is 0.
- Storage is a compacting queue: slot 0 is always the oldest. Valid entries are contiguous from slot 0.
- Dispatch handshake: an entry is written when disp_valid && disp_ready. It goes to slot count, or slot count-1 if an issue removes an entry in the same cycle.
- disp_ready does not credit a same-cycle issue, so a full queue refuses dispatch even while issuing.
- Wakeup: on cdb_valid, every valid entry with a not-ready source whose tag equals cdb_tag latches cdb_data and sets that ready bit. Both sources of one entry may wake together.
- Dispatch-cycle wakeup: if a dispatched not-ready source tag equals cdb_tag while cdb_valid, the entry is written already ready, holding cdb_data.
- Select: the lowest-index entry with both sources ready, using ready state as registered at the start of the cycle. An entry woken in cycle N is first selectable in cycle N+1.
- Issue: when a ready entry exists and !alu_stall, it is removed (younger entries shift down one slot). Its fields load the issue register at the clock edge; issue_valid is 1 in the next cycle.
- If no ready entry exists or alu_stall=1, issue_valid becomes 0 next cycle. The queue is unchanged except for dispatch and wakeup.
- Issue latency: dispatch of an all-ready op into an empty queue at edge N gives issue_valid=1 after edge N+1.
- flush: all entries are invalidated, count becomes 0 and issue_valid becomes 0 at the next edge. Same-cycle dispatch and wakeup are ignored. flush has priority over everything except rst_n.
- Reset asserted mid-operation: all state clears immediately, with no partial issue.
- Tag compare is exact over TAG_W bits. No ordering is implied between identical in-flight tags.

Optional Feature:
- ALU_ISSUE_WAKEUP_BYPASS_EN defined: select also considers sources being woken by the current CDB broadcast. Such an entry may issue in the same cycle, with cdb_data muxed onto the matching operand, giving back-to-back dependent issue.
- ALU_ISSUE_WAKEUP_BYPASS_EN undefined: woken entries wait one cycle, as described above.

Test Plan:
- Reset then dispatch one ready op: add, src1=5, src2=7, dst_tag=3 → next cycle issue_valid=1, src_1=5, src_2=7, issue_dst_tag=3; count returns to 0.
- Dispatch op A waiting on tag 9, then op B all-ready → B issues first. Then cdb_valid, tag 9, data 0x100 → A issues one cycle later with src_1=0x100 (same cycle with the macro defined).
- Fill 4 entries, none ready → disp_ready=0, count=4. Wake slot 2 → slot 2 issues, slot 3 moves to slot 2, disp_ready returns to 1.
- Two ready entries with alu_stall=1 for 3 cycles → issue_valid=0 throughout. Release stall → oldest issues first, then the younger one.
- Dispatch with src2 tag 6 in the same cycle as cdb tag 6, data 0xABCD → entry issues with src_2=0xABCD.
- flush with 3 entries plus a pending issue → next cycle count=0, issue_valid=0. Assert rst_n=0 mid-queue → outputs clear asynchronously.
